// File: rtl/fsm_seq_checker_if.sv
// Sample/status bundle for fsm_seq_checker: the observed code stream in,
// the lock status and error/wrap counters out.
interface fsm_seq_checker_if #(
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic [2:0]       in_code;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
  logic [2:0]       expected;
  logic [1:0]       chk_state;

  modport master (
    output in_valid, in_code, clr_cnt,
    input  locked, err_pulse, err_count, wrap_count, expected, chk_state
  );

  modport slave (
    input  in_valid, in_code, clr_cnt,
    output locked, err_pulse, err_count, wrap_count, expected, chk_state
  );
endinterface

// File: rtl/fsm_seq_checker.sv
// Tracks a 0..7 cycling counter: hunts for phase, locks after LOCK_N
// in-order samples, flywheels through up to UNLOCK_N-1 misses while locked.
module fsm_seq_checker #(
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst,
  fsm_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10,
    SLIP   = 2'b11
  } state_t;

  localparam logic [3:0]       LOCK_LAST   = 4'(LOCK_N - 1);
  localparam logic [3:0]       UNLOCK_LAST = 4'(UNLOCK_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  state_t           state_r, state_s;
  logic [2:0]       exp_r, exp_s;
  logic [3:0]       match_cnt_r, match_cnt_s;
  logic [3:0]       miss_cnt_r, miss_cnt_s;
  logic [CNT_W-1:0] err_count_r, err_count_s;
  logic [CNT_W-1:0] wrap_count_r, wrap_count_s;
  logic             locked_r, locked_s;
  logic             err_pulse_r;
  logic             match_s;
  logic             err_s;
  logic             wrap_s;

  // Next-state, expected-code, counter and status computation
  always_comb begin
    state_s      = state_r;
    exp_s        = exp_r;
    match_cnt_s  = match_cnt_r;
    miss_cnt_s   = miss_cnt_r;
    err_count_s  = err_count_r;
    wrap_count_s = wrap_count_r;
    err_s        = 1'b0;
    wrap_s       = 1'b0;
    match_s      = (bus.in_code == exp_r);

    if (bus.in_valid) begin
      exp_s = exp_r + 3'd1;
      case (state_r)
        HUNT: begin
          exp_s       = bus.in_code + 3'd1;
          match_cnt_s = 4'd0;
          miss_cnt_s  = 4'd0;
          state_s     = SYNC;
        end
        SYNC: begin
          if (match_s) begin
            match_cnt_s = match_cnt_r + 4'd1;
            if (match_cnt_r == LOCK_LAST) begin
              state_s    = LOCKED;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = SYNC;
            end
          end else begin
            // Resynchronise silently on the observed code
            exp_s       = bus.in_code + 3'd1;
            match_cnt_s = 4'd0;
          end
        end
        LOCKED: begin
          if (match_s) begin
            wrap_s = (bus.in_code == 3'd7);
          end else begin
            err_s      = 1'b1;
            miss_cnt_s = 4'd1;
            if (UNLOCK_N == 1) begin
              state_s = HUNT;
            end else begin
              state_s = SLIP;
            end
          end
        end
        SLIP: begin
          if (match_s) begin
            wrap_s     = (bus.in_code == 3'd7);
            miss_cnt_s = 4'd0;
            state_s    = LOCKED;
          end else begin
            err_s      = 1'b1;
            miss_cnt_s = miss_cnt_r + 4'd1;
            if (miss_cnt_r == UNLOCK_LAST) begin
              state_s = HUNT;
            end else begin
              state_s = SLIP;
            end
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // Clear wins over a same-edge increment; error count saturates
    if (bus.clr_cnt) begin
      err_count_s  = CNT_ZERO;
      wrap_count_s = CNT_ZERO;
    end else begin
      if (err_s && (err_count_r != CNT_MAX)) begin
        err_count_s = err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_count_s = err_count_r;
      end
      if (wrap_s) begin
        wrap_count_s = wrap_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wrap_count_s = wrap_count_r;
      end
    end

    locked_s = (state_s == LOCKED) || (state_s == SLIP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= HUNT;
      exp_r        <= 3'd0;
      match_cnt_r  <= 4'd0;
      miss_cnt_r   <= 4'd0;
      err_count_r  <= CNT_ZERO;
      wrap_count_r <= CNT_ZERO;
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      exp_r        <= exp_s;
      match_cnt_r  <= match_cnt_s;
      miss_cnt_r   <= miss_cnt_s;
      err_count_r  <= err_count_s;
      wrap_count_r <= wrap_count_s;
      locked_r     <= locked_s;
      err_pulse_r  <= err_s;
    end
  end

  assign bus.chk_state  = state_r;
  assign bus.expected   = exp_r;
  assign bus.locked     = locked_r;
  assign bus.err_pulse  = err_pulse_r;
  assign bus.err_count  = err_count_r;
  assign bus.wrap_count = wrap_count_r;

endmodule
